// File: rtl/multicycle_control_fsm.sv
// Moore control FSM for a shared multicycle RV32I datapath. Optional feature: ILLEGAL_OP_TRAP_EN (TRAP state + IllegalOp).
// Latency (MemReady high): beq 3, R/I/sw/jal 4, lw 5 cycles.
// Backpressure: FETCH/MEMREAD/MEMWRITE hold until MemReady; each wait cycle adds one.
module multicycle_control_fsm #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       funct3_0,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       MemReq,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUOp,
  output logic [1:0] ImmSrc
`ifdef ILLEGAL_OP_TRAP_EN
  ,
  output logic       IllegalOp
`endif
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_EXECUTEI = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_JAL      = 4'd9;
  localparam logic [3:0] S_BEQ      = 4'd10;
`ifdef ILLEGAL_OP_TRAP_EN
  localparam logic [3:0] S_TRAP     = 4'd11;
`endif

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BR  = 7'b1100011;

  logic [3:0] state;
  logic [3:0] state_nxt;
  logic       pc_update;
  logic       branch;

  always_ff @(posedge clk) begin
    if (reset) state <= RESET_STATE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = S_FETCH;
    case (state)
      S_FETCH:    state_nxt = MemReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_R:         state_nxt = S_EXECUTER;
          OP_I:         state_nxt = S_EXECUTEI;
          OP_JAL:       state_nxt = S_JAL;
          OP_BR:        state_nxt = S_BEQ;
`ifdef ILLEGAL_OP_TRAP_EN
          default:      state_nxt = S_TRAP;
`else
          // PC was already advanced in FETCH, so dropping back is a clean NOP
          default:      state_nxt = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:   state_nxt = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_nxt = MemReady ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_nxt = S_FETCH;
      S_MEMWRITE: state_nxt = MemReady ? S_FETCH : S_MEMWRITE;
      S_EXECUTER: state_nxt = S_ALUWB;
      S_EXECUTEI: state_nxt = S_ALUWB;
      S_ALUWB:    state_nxt = S_FETCH;
      S_JAL:      state_nxt = S_ALUWB;
      S_BEQ:      state_nxt = S_FETCH;
`ifdef ILLEGAL_OP_TRAP_EN
      S_TRAP:     state_nxt = S_TRAP;
`endif
      default:    state_nxt = S_FETCH;
    endcase
  end

  always_comb begin
    pc_update = 1'b0;
    branch    = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    MemWrite  = 1'b0;
    MemReq    = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    ALUOp     = 2'b00;
    if (reset) begin
      // Reset overrides whatever step was in flight: no enables, FETCH muxing
      ALUSrcB   = 2'b10;
      ResultSrc = 2'b10;
    end else begin
      case (state)
        S_FETCH: begin
          MemReq    = 1'b1;
          ALUSrcB   = 2'b10;
          ResultSrc = 2'b10;
          IRWrite   = MemReady;
          pc_update = MemReady;
        end
        S_DECODE: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b01;
        end
        S_MEMADR: begin
          ALUSrcA = 2'b10;
          ALUSrcB = 2'b01;
        end
        S_MEMREAD: begin
          MemReq = 1'b1;
          AdrSrc = 1'b1;
        end
        S_MEMWB: begin
          ResultSrc = 2'b01;
          RegWrite  = 1'b1;
        end
        S_MEMWRITE: begin
          MemReq   = 1'b1;
          AdrSrc   = 1'b1;
          MemWrite = MemReady;
        end
        S_EXECUTER: begin
          ALUSrcA = 2'b10;
          ALUOp   = 2'b10;
        end
        S_EXECUTEI: begin
          ALUSrcA = 2'b10;
          ALUSrcB = 2'b01;
          ALUOp   = 2'b10;
        end
        S_ALUWB: RegWrite = 1'b1;
        S_JAL: begin
          ALUSrcA   = 2'b01;
          ALUSrcB   = 2'b10;
          pc_update = 1'b1;
        end
        S_BEQ: begin
          ALUSrcA = 2'b10;
          ALUOp   = 2'b01;
          branch  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // funct3_0 inverts the sense of Zero so bne shares the beq step
  assign PCWrite = pc_update | (branch & (Zero ^ funct3_0));

  always_comb begin
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BR:   ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

`ifdef ILLEGAL_OP_TRAP_EN
  always_ff @(posedge clk) begin
    if (reset)                  IllegalOp <= 1'b0;
    else if (state_nxt == S_TRAP) IllegalOp <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: per-instruction cycle plans built from the instruction-level
// timing rules, replayed into the DUT and compared every cycle; honours ILLEGAL_OP_TRAP_EN.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op = 7'd0;
  logic       funct3_0 = 1'b0;
  logic       Zero = 1'b0;
  logic       MemReady = 1'b0;
  logic       PCWrite, IRWrite, RegWrite, MemWrite, MemReq, AdrSrc;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ALUOp, ImmSrc;
`ifdef ILLEGAL_OP_TRAP_EN
  logic       IllegalOp;
`endif

  multicycle_control_fsm dut (
    .clk(clk), .reset(reset), .op(op), .funct3_0(funct3_0), .Zero(Zero), .MemReady(MemReady),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .MemReq(MemReq), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ALUOp(ALUOp), .ImmSrc(ImmSrc)
`ifdef ILLEGAL_OP_TRAP_EN
    , .IllegalOp(IllegalOp)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] JAL = 7'b1101111;
  localparam logic [6:0] BR  = 7'b1100011;

  // en = {PCWrite, IRWrite, RegWrite, MemWrite, MemReq}; care = {adr, srca, srcb, res, aluop}
  typedef struct {
    logic       rst;
    logic       mr;
    logic [6:0] op;
    logic       f3;
    logic       z;
    logic [4:0] en;
    logic       ill;
    logic [4:0] care;
    logic       adr;
    logic [1:0] sa, sb, rs, ao;
  } cyc_t;

  cyc_t plan_q[$];
  cyc_t exp_q[$];
  cyc_t ce;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  logic model_ill = 1'b0;

  function automatic cyc_t blank(logic [6:0] o, logic f3, logic z);
    cyc_t r;
    r.rst = 1'b0; r.mr = 1'b0; r.op = o; r.f3 = f3; r.z = z;
    r.en = 5'b0; r.ill = 1'b0; r.care = 5'b0; r.adr = 1'b0;
    r.sa = 2'b00; r.sb = 2'b00; r.rs = 2'b00; r.ao = 2'b00;
    return r;
  endfunction

  function automatic cyc_t mx(cyc_t r0, logic [4:0] c, logic a, logic [1:0] sa,
                              logic [1:0] sb, logic [1:0] rs, logic [1:0] ao);
    cyc_t r;
    r = r0; r.care = c; r.adr = a; r.sa = sa; r.sb = sb; r.rs = rs; r.ao = ao;
    return r;
  endfunction

  function automatic logic [1:0] imm_of(logic [6:0] o);
    if (o == SW)  return 2'b01;
    if (o == BR)  return 2'b10;
    if (o == JAL) return 2'b11;
    return 2'b00;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  task automatic pin(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL model_%s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic push_reset(input int n);
    cyc_t r;
    for (int i = 0; i < n; i++) begin
      r = mx(blank(7'd0, 1'b0, 1'b0), 5'b11111, 1'b0, 2'b00, 2'b10, 2'b10, 2'b00);
      r.rst = 1'b1;
      r.mr  = 1'b1;
      r.ill = (i == 0) ? model_ill : 1'b0;
      plan_q.push_back(r);
    end
    model_ill = 1'b0;
  endtask

  // Builds one instruction's cycles: fw = FETCH wait cycles, mw = memory wait cycles,
  // keep < 0 keeps all cycles, else only the first keep cycles (for mid-instruction reset).
  task automatic model_instr(input logic [6:0] o, input logic f3, input logic z,
                             input int fw, input int mw, input int keep);
    cyc_t t[$];
    cyc_t r;
    for (int i = 0; i <= fw; i++) begin
      r = mx(blank(o, f3, z), 5'b11111, 1'b0, 2'b00, 2'b10, 2'b10, 2'b00);
      r.mr = (i == fw);
      r.en = (i == fw) ? 5'b11001 : 5'b00001;
      t.push_back(r);
    end
    t.push_back(mx(blank(o, f3, z), 5'b01101, 1'b0, 2'b01, 2'b01, 2'b00, 2'b00));
    if (o == RT || o == IT) begin
      t.push_back(mx(blank(o, f3, z), 5'b01101, 1'b0, 2'b10, (o == IT) ? 2'b01 : 2'b00,
                     2'b00, 2'b10));
      r = mx(blank(o, f3, z), 5'b00010, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
      r.en = 5'b00100;
      t.push_back(r);
    end else if (o == LW || o == SW) begin
      t.push_back(mx(blank(o, f3, z), 5'b01101, 1'b0, 2'b10, 2'b01, 2'b00, 2'b00));
      for (int i = 0; i <= mw; i++) begin
        r = mx(blank(o, f3, z), 5'b10010, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00);
        r.mr = (i == mw);
        r.en = (o == SW && i == mw) ? 5'b00011 : 5'b00001;
        t.push_back(r);
      end
      if (o == LW) begin
        r = mx(blank(o, f3, z), 5'b00010, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00);
        r.en = 5'b00100;
        t.push_back(r);
      end
    end else if (o == JAL) begin
      r = mx(blank(o, f3, z), 5'b01110, 1'b0, 2'b01, 2'b10, 2'b00, 2'b00);
      r.en = 5'b10000;
      t.push_back(r);
      r = mx(blank(o, f3, z), 5'b00010, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
      r.en = 5'b00100;
      t.push_back(r);
    end else if (o == BR) begin
      r = mx(blank(o, f3, z), 5'b01111, 1'b0, 2'b10, 2'b00, 2'b00, 2'b01);
      r.en = {z ^ f3, 4'b0000};
      t.push_back(r);
    end else begin
`ifdef ILLEGAL_OP_TRAP_EN
      for (int i = 0; i < 4; i++) begin
        r = blank(o, f3, z);
        r.mr  = 1'b1;
        r.ill = 1'b1;
        t.push_back(r);
      end
      model_ill = 1'b1;
`endif
    end
    for (int k = 0; k < t.size(); k++)
      if (keep < 0 || k < keep) plan_q.push_back(t[k]);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      ce = exp_q.pop_front();
      chk("enables", {3'b0, PCWrite, IRWrite, RegWrite, MemWrite, MemReq}, {3'b0, ce.en});
      if (ce.care[4]) chk("AdrSrc", {7'b0, AdrSrc}, {7'b0, ce.adr});
      if (ce.care[3]) chk("ALUSrcA", {6'b0, ALUSrcA}, {6'b0, ce.sa});
      if (ce.care[2]) chk("ALUSrcB", {6'b0, ALUSrcB}, {6'b0, ce.sb});
      if (ce.care[1]) chk("ResultSrc", {6'b0, ResultSrc}, {6'b0, ce.rs});
      if (ce.care[0]) chk("ALUOp", {6'b0, ALUOp}, {6'b0, ce.ao});
      chk("ImmSrc", {6'b0, ImmSrc}, {6'b0, imm_of(ce.op)});
`ifdef ILLEGAL_OP_TRAP_EN
      chk("IllegalOp", {7'b0, IllegalOp}, {7'b0, ce.ill});
`endif
      cyc++;
    end
  end

  initial begin
    int s0;
    int nmw;
    cyc_t r;
    push_reset(2);
    s0 = plan_q.size();
    model_instr(RT, 1'b0, 1'b0, 0, 0, -1);
    pin("add_len", plan_q.size() - s0, 4);
    pin("add_irw_c0", int'(plan_q[s0].en[3]), 1);
    pin("add_rw_c3", int'(plan_q[s0 + 3].en[2]), 1);
    model_instr(IT, 1'b0, 1'b0, 2, 0, -1);
    s0 = plan_q.size();
    model_instr(LW, 1'b0, 1'b0, 0, 3, -1);
    pin("lw_wait3_len", plan_q.size() - s0, 8);
    model_instr(LW, 1'b0, 1'b0, 1, 0, -1);
    s0 = plan_q.size();
    model_instr(SW, 1'b0, 1'b0, 0, 2, -1);
    nmw = 0;
    for (int k = s0; k < plan_q.size(); k++) nmw += int'(plan_q[k].en[1]);
    pin("sw_memwrite_count", nmw, 1);
    pin("sw_memwrite_c5", int'(plan_q[s0 + 5].en[1]), 1);
    s0 = plan_q.size();
    model_instr(BR, 1'b0, 1'b1, 0, 0, -1);
    pin("beq_taken_c2", int'(plan_q[s0 + 2].en[4]), 1);
    s0 = plan_q.size();
    model_instr(BR, 1'b1, 1'b1, 0, 0, -1);
    pin("bne_not_taken_c2", int'(plan_q[s0 + 2].en[4]), 0);
    model_instr(BR, 1'b1, 1'b0, 1, 0, -1);
    model_instr(BR, 1'b0, 1'b0, 0, 0, -1);
    model_instr(JAL, 1'b0, 1'b0, 0, 0, -1);
    model_instr(LW, 1'b0, 1'b0, 0, 0, 3);
    push_reset(1);
    model_instr(SW, 1'b0, 1'b0, 0, 0, 3);
    push_reset(1);
    s0 = plan_q.size();
    model_instr(7'h7F, 1'b0, 1'b0, 0, 0, -1);
`ifndef ILLEGAL_OP_TRAP_EN
    pin("nop_len", plan_q.size() - s0, 2);
`endif
    push_reset(2);
    model_instr(RT, 1'b0, 1'b0, 0, 0, -1);

    while (plan_q.size() > 0) begin
      @(posedge clk);
      #1;
      r = plan_q.pop_front();
      reset    = r.rst;
      MemReady = r.mr;
      op       = r.op;
      funct3_0 = r.f3;
      Zero     = r.z;
      exp_q.push_back(r);
    end
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
